sram_arbiter: RTL

Two-port arbiter and access sequencer for the external 8-bit asynchronous SRAM on the 6502 FPGA design. The block sits between the SRAM pins and two requesters: the CPU-side page-3 decode and a DMA engine. It serialises their accesses with round-robin priority. It also generates the address-setup, strobe and hold phases, with programmable wait states.

---
 rtl/sram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the external 8-bit async SRAM.
// Each access runs SETUP -> ACTIVE (strobe, N+1 cycles) -> DONE (hold + ack).
module sram_arbiter #(
  parameter int AW      = 16,
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic          dma_ack,
  output logic [7:0]    dma_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  output logic          sram_dout_en,
  output logic          sram_oe,
  output logic          sram_we,
  input  logic [7:0]    sram_din
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, DONE} state_t;

  localparam logic [3:0] N_RD = 4'(WAIT_RD);
  localparam logic [3:0] N_WR = 4'(WAIT_WR);

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          last_grant_q, last_grant_d;
  logic          acc_we_q, acc_we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          oe_q, oe_d;
  logic          we_q, we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    dma_rdata_q, dma_rdata_d;
  logic          grant;
  logic          gport;

  // last_grant doubles as the identity of the port currently being served.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    last_grant_d = last_grant_q;
    acc_we_d     = acc_we_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    dout_en_d    = dout_en_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    grant        = 1'b0;
    gport        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant = 1'b1;
          gport = (cpu_req && dma_req) ? ~last_grant_q : dma_req;
        end
      end
      SETUP: begin
        state_d = ACTIVE;
        wcnt_d  = acc_we_q ? N_WR : N_RD;
      end
      ACTIVE: begin
        if (wcnt_q == '0) begin
          state_d = DONE;
          if (!acc_we_q) begin
            if (last_grant_q) dma_rdata_d = sram_din;
            else              cpu_rdata_d = sram_din;
          end
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      DONE: begin
        // Only the port not just served may be granted; the served port may still hold req.
        if (last_grant_q ? cpu_req : dma_req) begin
          grant = 1'b1;
          gport = ~last_grant_q;
        end else begin
          state_d   = IDLE;
          dout_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d      = SETUP;
      last_grant_d = gport;
      acc_we_d     = gport ? dma_we    : cpu_we;
      addr_d       = gport ? dma_addr  : cpu_addr;
      dout_d       = gport ? dma_wdata : cpu_wdata;
      dout_en_d    = acc_we_d;
    end

    oe_d      = (state_d == ACTIVE) && !acc_we_d;
    we_d      = (state_d == ACTIVE) &&  acc_we_d;
    cpu_ack_d = (state_d == DONE) && !last_grant_d;
    dma_ack_d = (state_d == DONE) &&  last_grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      last_grant_q <= 1'b1;
      acc_we_q     <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      dout_en_q    <= 1'b0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      last_grant_q <= last_grant_d;
      acc_we_q     <= acc_we_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = dout_en_q;
  assign sram_oe      = oe_q;
  assign sram_we      = we_q;
  assign cpu_ack      = cpu_ack_q;
  assign dma_ack      = dma_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dma_rdata    = dma_rdata_q;

endmodule
